// File: rtl/rx_pkg.sv
// Shared definitions for the 64b/66b receive path: widths, block-type codes,
// XGMII characters, fixed output blocks, class/state enums and decode helpers.
package rx_pkg;

    localparam int unsigned LEN_CODED_BLOCK = 66;
    localparam int unsigned LEN_DATA_BLOCK  = 64;
    localparam int unsigned LEN_CTRL_BLOCK  = 8;
    localparam int unsigned LEN_SCR_STATE   = 58;
    localparam int unsigned LEN_ERR_COUNT   = 16;
    localparam int unsigned N_LANES         = 8;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] TYPE_C = 8'h1E;
    localparam logic [7:0] TYPE_S = 8'h78;

    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_ERROR = 8'hFE;
    localparam logic [7:0] CH_SEQ   = 8'h9C;

    localparam logic [LEN_DATA_BLOCK-1:0] LF_DATA  = {CH_SEQ, 24'h00_0001, CH_SEQ, 24'h00_0001};
    localparam logic [LEN_CTRL_BLOCK-1:0] LF_CTRL  = 8'h88;
    localparam logic [LEN_DATA_BLOCK-1:0] ERR_DATA = {N_LANES{CH_ERROR}};
    localparam logic [LEN_CTRL_BLOCK-1:0] ERR_CTRL = 8'hFF;

    typedef enum logic [2:0] {CLS_D, CLS_C, CLS_S, CLS_T, CLS_E} blk_class_e;
    typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rx_state_e;

    typedef struct packed {
        blk_class_e                cls;
        logic [LEN_DATA_BLOCK-1:0] data;
        logic [LEN_CTRL_BLOCK-1:0] ctrl;
    } rx_blk_t;

    localparam rx_blk_t ERR_BLK = '{cls: CLS_E, data: ERR_DATA, ctrl: ERR_CTRL};

    // Data-byte count of a terminate block type; 8 marks "not a terminate".
    function automatic logic [3:0] term_len(input logic [7:0] btype);
        case (btype)
            8'h87:   return 4'd0;
            8'h99:   return 4'd1;
            8'hAA:   return 4'd2;
            8'hB4:   return 4'd3;
            8'hCC:   return 4'd4;
            8'hD2:   return 4'd5;
            8'hE1:   return 4'd6;
            8'hFF:   return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

    function automatic rx_state_e rx_next_state(input rx_state_e st, input blk_class_e cls);
        case (st)
            RX_INIT, RX_C, RX_T: begin
                if (cls == CLS_C)      return RX_C;
                else if (cls == CLS_S) return RX_D;
                else                   return RX_E;
            end
            RX_D: begin
                if (cls == CLS_D)      return RX_D;
                else if (cls == CLS_T) return RX_T;
                else                   return RX_E;
            end
            default: begin
                if (cls == CLS_C)      return RX_C;
                else if (cls == CLS_D) return RX_D;
                else if (cls == CLS_T) return RX_T;
                else                   return RX_E;
            end
        endcase
    endfunction

endpackage

// File: rtl/rx_decoder_path_if.sv
// Block-stream interface of the receive decoder: coded blocks in, XGMII lanes out.
// o_err_count exists only when RX_DECODER_ERRCNT_EN is defined.
interface rx_decoder_path_if;
    import rx_pkg::*;

    logic                       i_enable;
    logic [LEN_CODED_BLOCK-1:0] i_rx_coded;
    logic [LEN_DATA_BLOCK-1:0]  o_rx_data;
    logic [LEN_CTRL_BLOCK-1:0]  o_rx_ctrl;
`ifdef RX_DECODER_ERRCNT_EN
    logic [LEN_ERR_COUNT-1:0]   o_err_count;

    modport master (output i_enable, i_rx_coded, input o_rx_data, o_rx_ctrl, o_err_count);
    modport slave  (input i_enable, i_rx_coded, output o_rx_data, o_rx_ctrl, o_err_count);
`else
    modport master (output i_enable, i_rx_coded, input o_rx_data, o_rx_ctrl);
    modport slave  (input i_enable, i_rx_coded, output o_rx_data, o_rx_ctrl);
`endif

endinterface

// File: rtl/rx_descrambler.sv
// Self-synchronizing x^58+x^39+1 descrambler, MSB first; the sync header passes
// through untouched. Output is registered (pipeline stage 1).
module rx_descrambler
    import rx_pkg::*;
#(
    parameter logic [LEN_SCR_STATE-1:0] SEED = '0
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_bypass,
    input  logic [LEN_CODED_BLOCK-1:0] i_coded,
    output logic [LEN_CODED_BLOCK-1:0] o_coded
);

    logic [LEN_SCR_STATE-1:0]  state;
    logic [LEN_SCR_STATE-1:0]  state_nxt_c;
    logic [LEN_DATA_BLOCK-1:0] plain_c;

    // Received (scrambled) bits feed the state, which is what makes it self-synchronizing.
    always_comb begin
        state_nxt_c = state;
        plain_c     = '0;
        for (int i = int'(LEN_DATA_BLOCK) - 1; i >= 0; i--) begin
            plain_c[i]  = i_coded[i] ^ state_nxt_c[38] ^ state_nxt_c[57];
            state_nxt_c = {state_nxt_c[LEN_SCR_STATE-2:0], i_coded[i]};
        end
    end

    // Reset leaves sync 2'b00 in the stage, which classifies as an error block.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state   <= SEED;
            o_coded <= '0;
        end else if (i_enable) begin
            state   <= state_nxt_c;
            o_coded <= {i_coded[LEN_CODED_BLOCK-1:LEN_DATA_BLOCK], i_bypass ? i_coded[LEN_DATA_BLOCK-1:0] : plain_c};
        end
    end

endmodule

// File: rtl/rx_decoder_path.sv
// 64b/66b receive path: descramble, classify, receive FSM -> XGMII data/ctrl, 3-cycle latency.
// Optional error counter on o_err_count when RX_DECODER_ERRCNT_EN is defined.
module rx_decoder_path
    import rx_pkg::*;
#(
    parameter logic [LEN_SCR_STATE-1:0] SEED = '0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    rx_decoder_path_if.slave  rx
);

    logic [LEN_CODED_BLOCK-1:0] s1_coded;
    rx_blk_t                    blk_c;
    rx_blk_t                    s2_blk;
    logic [1:0]                 fill;
    logic [LEN_DATA_BLOCK-1:0]  sh_c;
    logic [7:0]                 btype_c;
    logic [3:0]                 tlen_c;
    logic [6:0]                 code_c;
    logic                       codes_ok_c;
    rx_state_e                  state;
    rx_state_e                  state_nxt_c;
    logic [LEN_DATA_BLOCK-1:0]  data_q;
    logic [LEN_CTRL_BLOCK-1:0]  ctrl_q;

    rx_descrambler #(.SEED(SEED)) u_descrambler (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_enable (rx.i_enable),
        .i_bypass (1'b0),
        .i_coded  (rx.i_rx_coded),
        .o_coded  (s1_coded)
    );

    // Block classification and lane decode.
    always_comb begin
        sh_c       = {s1_coded[55:0], 8'h00};
        btype_c    = s1_coded[63:56];
        tlen_c     = term_len(btype_c);
        code_c     = '0;
        codes_ok_c = 1'b1;
        blk_c      = ERR_BLK;
        if (s1_coded[65:64] == SYNC_DATA) begin
            blk_c = '{cls: CLS_D, data: s1_coded[63:0], ctrl: '0};
        end else if (s1_coded[65:64] == SYNC_CTRL) begin
            if (btype_c == TYPE_C) begin
                blk_c.ctrl = '1;
                for (int unsigned i = 0; i < N_LANES; i++) begin
                    code_c = s1_coded[55 - 7*i -: 7];
                    if (code_c == CODE_IDLE)       blk_c.data[63 - 8*i -: 8] = CH_IDLE;
                    else if (code_c == CODE_ERROR) blk_c.data[63 - 8*i -: 8] = CH_ERROR;
                    else                           codes_ok_c = 1'b0;
                end
                blk_c.cls = codes_ok_c ? CLS_C : CLS_E;
            end else if (btype_c == TYPE_S) begin
                blk_c = '{cls: CLS_S, data: {CH_START, s1_coded[55:0]}, ctrl: 8'h80};
            end else if (tlen_c != 4'd8) begin
                blk_c.cls = CLS_T;
                for (int unsigned i = 0; i < N_LANES; i++) begin
                    if (4'(i) < tlen_c) begin
                        blk_c.data[63 - 8*i -: 8] = sh_c[63 - 8*i -: 8];
                        blk_c.ctrl[7 - i]         = 1'b0;
                    end else if (4'(i) == tlen_c) begin
                        blk_c.data[63 - 8*i -: 8] = CH_TERM;
                        blk_c.ctrl[7 - i]         = 1'b1;
                    end else begin
                        blk_c.data[63 - 8*i -: 8] = CH_IDLE;
                        blk_c.ctrl[7 - i]         = 1'b1;
                    end
                end
            end
        end
    end

    // fill keeps the FSM in RX_INIT until real blocks have reached stage 2 after reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            s2_blk <= ERR_BLK;
            fill   <= '0;
        end else if (rx.i_enable) begin
            s2_blk <= blk_c;
            fill   <= {fill[0], 1'b1};
        end
    end

    assign state_nxt_c = rx_next_state(state, s2_blk.cls);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state  <= RX_INIT;
            data_q <= LF_DATA;
            ctrl_q <= LF_CTRL;
        end else if (rx.i_enable && fill[1]) begin
            state <= state_nxt_c;
            if (state_nxt_c == RX_E) begin
                data_q <= ERR_DATA;
                ctrl_q <= ERR_CTRL;
            end else begin
                data_q <= s2_blk.data;
                ctrl_q <= s2_blk.ctrl;
            end
        end
    end

    assign rx.o_rx_data = data_q;
    assign rx.o_rx_ctrl = ctrl_q;

`ifdef RX_DECODER_ERRCNT_EN
    logic [LEN_ERR_COUNT-1:0] err_q;

    // Saturating count of cycles spent entering or staying in RX_E.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            err_q <= '0;
        end else if (rx.i_enable && fill[1] && state_nxt_c == RX_E && err_q != '1) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign rx.o_err_count = err_q;
`endif

endmodule

// File: tb/tb_rx_decoder_path.sv
// Self-checking bench for rx_decoder_path: table of blocks scrambled by a reference
// scrambler, scoreboard of expected XGMII output, plus freeze/reset/error-run sequences.
module tb_rx_decoder_path;
    import rx_pkg::*;

    typedef struct {
        logic [1:0]  sync;
        logic [63:0] plain;
        logic [63:0] exp_data;
        logic [7:0]  exp_ctrl;
        int          exp_cnt;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
        int          cnt;
        int          tag;
    } exp_t;

    localparam logic [63:0] IDLE_P = {8'h1E, 56'h0};
    localparam logic [63:0] IDLE_D = 64'h0707_0707_0707_0707;
    localparam logic [63:0] ERR_D  = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [63:0] LF_D   = 64'h9C00_0001_9C00_0001;

    logic clk = 1'b0;
    logic rst;

    rx_decoder_path_if rxif ();

    rx_decoder_path u_dut (
        .i_clock (clk),
        .i_reset (rst),
        .rx      (rxif.slave)
    );

    always #5 clk = ~clk;

    vec_t        vecs[$];
    exp_t        sb[$];
    logic [57:0] scr_state = '0;
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] last_data = '0;
    logic [7:0]  last_ctrl = '0;

    // Reference scrambler: the transmitted bit is shifted into the state.
    function automatic logic [63:0] scramble(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 63; i >= 0; i--) begin
            o[i]      = d[i] ^ scr_state[38] ^ scr_state[57];
            scr_state = {scr_state[56:0], o[i]};
        end
        return o;
    endfunction

    function automatic void add(input logic [1:0] s, input logic [63:0] p, input logic [63:0] d,
                                input logic [7:0] c, input int cnt);
        vec_t v;
        v.sync = s; v.plain = p; v.exp_data = d; v.exp_ctrl = c; v.exp_cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic check64(input string name, input int tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %h, expected %h", name, tag, got, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_underflow: got no expectation, expected one");
            return;
        end
        e = sb.pop_front();
        check64("data", e.tag, rxif.o_rx_data, e.data);
        check64("ctrl", e.tag, 64'(rxif.o_rx_ctrl), 64'(e.ctrl));
`ifdef RX_DECODER_ERRCNT_EN
        if (e.cnt >= 0) check64("err_count", e.tag, 64'(rxif.o_err_count), 64'(e.cnt));
`endif
        last_data = e.data;
        last_ctrl = e.ctrl;
    endtask

    task automatic send(input logic [1:0] s, input logic [63:0] p, input logic [63:0] d,
                        input logic [7:0] c, input int cnt, input int tag);
        exp_t e;
        rxif.i_rx_coded = {s, scramble(p)};
        e = '{data: d, ctrl: c, cnt: cnt, tag: tag};
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic push_lf();
        exp_t e;
        e = '{data: LF_D, ctrl: 8'h88, cnt: 0, tag: -1};
        sb.push_back(e);
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input int tag);
        check64("reset_data", tag, rxif.o_rx_data, LF_D);
        check64("reset_ctrl", tag, 64'(rxif.o_rx_ctrl), 64'h88);
`ifdef RX_DECODER_ERRCNT_EN
        check64("reset_err_count", tag, 64'(rxif.o_err_count), 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        rxif.i_enable   = 1'b1;
        rxif.i_rx_coded = '0;

        for (int i = 0; i < 10; i++) add(2'b10, IDLE_P, IDLE_D, 8'hFF, 0);
        add(2'b10, {8'h78, 56'h11_2233_4455_6677}, 64'hFB11_2233_4455_6677, 8'h80, -1);
        add(2'b01, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'h00, -1);
        add(2'b01, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 8'h00, -1);
        add(2'b01, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 8'h00, -1);
        add(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, -1);
        add(2'b10, {8'hB4, 24'hA1A2A3, 32'h0}, 64'hA1A2_A3FD_0707_0707, 8'h1F, -1);
        add(2'b10, IDLE_P, IDLE_D, 8'hFF, 0);
        add(2'b10, {8'h78, 56'hAA_BBCC_DDEE_FF00}, 64'hFBAA_BBCC_DDEE_FF00, 8'h80, -1);
        add(2'b10, {8'h87, 56'h0}, 64'hFD07_0707_0707_0707, 8'hFF, -1);
        add(2'b10, {8'h1E, 7'h1E, 49'h0}, 64'hFE07_0707_0707_0707, 8'hFF, 0);
        add(2'b10, {8'h78, 56'h01_0203_0405_0607}, 64'hFB01_0203_0405_0607, 8'h80, -1);
        add(2'b01, 64'h5555_AAAA_5555_AAAA, 64'h5555_AAAA_5555_AAAA, 8'h00, -1);
        add(2'b10, {8'hFF, 56'hB1_B2B3_B4B5_B6B7}, 64'hB1B2_B3B4_B5B6_B7FD, 8'h01, -1);
        add(2'b10, IDLE_P, IDLE_D, 8'hFF, 0);
        add(2'b10, {8'h78, 56'h10_1112_1314_1516}, 64'hFB10_1112_1314_1516, 8'h80, -1);
        add(2'b01, 64'h2021_2223_2425_2627, 64'h2021_2223_2425_2627, 8'h00, -1);
        add(2'b10, {8'h78, 56'h30_3132_3334_3536}, ERR_D, 8'hFF, 1);
        add(2'b10, IDLE_P, IDLE_D, 8'hFF, 1);
        add(2'b10, {8'h1E, 21'h0, 7'h2D, 28'h0}, ERR_D, 8'hFF, 2);
        add(2'b10, IDLE_P, IDLE_D, 8'hFF, 2);
        add(2'b10, {8'h55, 56'h0}, ERR_D, 8'hFF, 3);
        add(2'b10, IDLE_P, IDLE_D, 8'hFF, 3);
        add(2'b10, {8'h78, 56'h40_4142_4344_4546}, 64'hFB40_4142_4344_4546, 8'h80, -1);
        add(2'b01, 64'h5051_5253_5455_5657, 64'h5051_5253_5455_5657, 8'h00, -1);
        add(2'b11, 64'h6061_6263_6465_6667, ERR_D, 8'hFF, 4);
        add(2'b01, 64'h7071_7273_7475_7677, 64'h7071_7273_7475_7677, 8'h00, 4);
        add(2'b01, 64'h8081_8283_8485_8687, 64'h8081_8283_8485_8687, 8'h00, 4);
        add(2'b10, {8'hB4, 24'h919293, 32'h0}, 64'h9192_93FD_0707_0707, 8'h1F, 4);
        add(2'b10, IDLE_P, IDLE_D, 8'hFF, 4);
        add(2'b00, IDLE_P, ERR_D, 8'hFF, 5);
        add(2'b10, {8'h87, 56'h0}, 64'hFD07_0707_0707_0707, 8'hFF, 5);
        add(2'b10, IDLE_P, IDLE_D, 8'hFF, 5);
        add(2'b10, IDLE_P, IDLE_D, 8'hFF, 5);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        rst = 1'b0;
        push_lf();

        for (int i = 0; i < vecs.size(); i++)
            send(vecs[i].sync, vecs[i].plain, vecs[i].exp_data, vecs[i].exp_ctrl, vecs[i].exp_cnt, i);

        // Clock enable low mid-frame: outputs hold, nothing lost afterwards.
        send(2'b10, {8'h78, 56'h31_3233_3435_3637}, 64'hFB31_3233_3435_3637, 8'h80, -1, 1000);
        send(2'b01, 64'hC0C1_C2C3_C4C5_C6C7, 64'hC0C1_C2C3_C4C5_C6C7, 8'h00, -1, 1001);
        rxif.i_enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rxif.i_rx_coded = {2'b11, 32'($urandom), 32'($urandom)};
            @(posedge clk);
            #1;
            check64("frozen_data", 3000 + k, rxif.o_rx_data, last_data);
            check64("frozen_ctrl", 3000 + k, 64'(rxif.o_rx_ctrl), 64'(last_ctrl));
        end
        rxif.i_enable = 1'b1;
        send(2'b01, 64'hD0D1_D2D3_D4D5_D6D7, 64'hD0D1_D2D3_D4D5_D6D7, 8'h00, -1, 1002);
        send(2'b01, 64'hE0E1_E2E3_E4E5_E6E7, 64'hE0E1_E2E3_E4E5_E6E7, 8'h00, -1, 1003);
        send(2'b10, {8'hB4, 24'hE1E2E3, 32'h0}, 64'hE1E2_E3FD_0707_0707, 8'h1F, -1, 1004);
        send(2'b10, IDLE_P, IDLE_D, 8'hFF, -1, 1005);
        send(2'b10, IDLE_P, IDLE_D, 8'hFF, -1, 1006);

        // Reset while in RX_D; the bench scrambler is not reset, so resync is exercised too.
        send(2'b10, {8'h78, 56'h71_7273_7475_7677}, 64'hFB71_7273_7475_7677, 8'h80, -1, 1007);
        send(2'b01, 64'h0F0E_0D0C_0B0A_0908, 64'h0F0E_0D0C_0B0A_0908, 8'h00, -1, 1008);
        send(2'b01, 64'h1F1E_1D1C_1B1A_1918, 64'h1F1E_1D1C_1B1A_1918, 8'h00, -1, 1009);
        rst = 1'b1;
        #1;
        check_reset_outputs(1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        push_lf();

        for (int i = 0; i < 70; i++)
            send(2'b11, {32'($urandom), 32'($urandom)}, ERR_D, 8'hFF, i + 1, 2000 + i);
        for (int i = 0; i < 4; i++)
            send(2'b10, IDLE_P, IDLE_D, 8'hFF, 70, 2100 + i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_decoder_path.md
# rx_decoder_path

Receive-side counterpart of the transmit encoder/scrambler chain: accepts 66-bit coded blocks from block alignment, descrambles the 64-bit payload with the self-synchronizing x^58+x^39+1 polynomial, classifies each block, and runs the 64b/66b receive state machine to regenerate 64-bit data plus 8-bit control (XGMII-style, 8 lanes). It sits between the lane-alignment/deskew stage and the MAC-side interface.

## Interface
- LEN_CODED_BLOCK, 66, coded block width (sync header + payload)
- LEN_DATA_BLOCK, 64, decoded data width
- LEN_CTRL_BLOCK, 8, control flags, one per byte lane
- SEED, 58'd0, descrambler state after reset
- i_clock  input  1  system clock, all logic on rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_enable  input  1  clock enable for every pipeline stage; low = all state holds
- i_rx_coded  input  66  [65:64] sync header, [63:0] scrambled payload, MSB transmitted first
- o_rx_data  output  64  decoded lanes, lane 0 = [63:56]
- o_rx_ctrl  output  8  bit 7 = lane 0; 1 = lane carries a control character
- o_err_count  output  16  only with RX_DECODER_ERRCNT_EN (see Configuration)

## Operation
- Stage 1 (descramble): payload descrambled MSB first, out = in ^ s[38] ^ s[57], received (scrambled) bit shifted into state; sync header passes unscrambled. State 58 bits, reset to SEED.
- Stage 2 (classify) into D/C/S/T/E:
  - sync 2'b01 → D.
  - sync 2'b10, type 0x1E, all eight 7-bit codes ∈ {0x00 idle, 0x1E error} → C; codes map to 0x07 / 0xFE.
  - type 0x78 → S: lane 0 = 0xFB, lanes 1-7 = payload[55:0].
  - types 0x87,0x99,0xAA,0xB4,0xCC,0xD2,0xE1,0xFF → T with k = 0..7 data bytes; lanes 0..k-1 data, lane k = 0xFD, remaining lanes 0x07.
  - sync 2'b00/2'b11, unknown type, or C with any other code → E.
- Stage 3 (FSM), registered outputs:
  - RX_INIT: C→RX_C, S→RX_D, else RX_E. Output while in RX_INIT = local-fault block.
  - RX_C: C→RX_C, S→RX_D, else RX_E.
  - RX_D: D→RX_D, T→RX_T, else RX_E.
  - RX_T: C→RX_C, S→RX_D, else RX_E.
  - RX_E: C→RX_C, D→RX_D, T→RX_T, else RX_E.
  - Entering RX_E outputs error block: data 64'hFEFE_FEFE_FEFE_FEFE, ctrl 8'hFF. Other states output the decoded block.
- Local-fault block: data 64'h9C00_0001_9C00_0001, ctrl 8'h88.

## Timing
- Reset: FSM = RX_INIT, o_rx_data = LF data, o_rx_ctrl = 8'h88, stage registers cleared to E, descrambler = SEED, o_err_count = 0.
- Latency 3 enabled cycles from i_rx_coded to o_rx_data/o_rx_ctrl.
- i_enable low: no register changes, outputs hold; no bubble insertion.
- Reset mid-frame: immediate return to reset values; first two outputs after release remain LF.
- Descrambler resynchronizes from line data within 58 payload bits regardless of SEED.

## Configuration
- RX_DECODER_ERRCNT_EN defined: o_err_count present; increments on each enabled cycle the FSM enters or stays in RX_E; saturates at 16'hFFFF; cleared only by i_reset.
- Not defined: port and counter absent; decode behaviour identical.

## Structure
- Shared package rx_pkg: block-type codes, XGMII characters (0x07, 0xFB, 0xFD, 0xFE, 0x9C), LF/error block constants, block-class and FSM state enums.
- Sub-module rx_descrambler (stage 1, parameter SEED, i_bypass tied low); classification and FSM stay in top.

## Test plan
- Reset, then 10 idle C blocks (sync 10, type 0x1E, zeros, pre-scrambled by reference model) → LF for 3 cycles, then data 64'h0707…07, ctrl 8'hFF.
- C, S, 4×D, T(k=3), C → 0xFB start lane, data passes, ctrl 8'h00 on D, T lanes 0-2 data, lane 3 0xFD, ctrl 8'h1F, then idle.
- Bad sync 2'b11 inside a frame → one error block (all 0xFE, ctrl 8'hFF), D after it → RX_D, data resumes.
- S after D (no T) → RX_E error block; with macro, o_err_count = 1.
- i_enable low 5 cycles mid-frame → outputs frozen, no blocks lost after re-enable.
- Assert i_reset during RX_D → LF immediately; 70 error blocks with macro → counter 70, no wrap.
